// File: rtl/pc_sequencer.sv
// pc_sequencer: 8-bit PC and fetch/execute sequencer for the 9-bit CPU; define PC_WRAP_TRAP_EN to halt with fault on PC carry/borrow
module pc_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             imem_req,
  output logic [7:0]       imem_addr,
  input  logic             imem_ack,
  input  logic [8:0]       imem_data,
  output logic [8:0]       instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             jmpf,
  input  logic             jmpb,
  input  logic [3:0]       offset,
  input  logic             halt_req,
  output logic [7:0]       pc,
  output logic             halted,
`ifdef PC_WRAP_TRAP_EN
  output logic             fault,
`endif
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, HALT} state_t;
`ifdef PC_WRAP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  state_t state;
  logic [8:0] nxt;
  assign imem_addr = pc;
  // Candidate next PC with bit 8 as carry (increment/jmpf) or borrow (jmpb)
  always_comb nxt = jmpf ? {1'b0, pc} + {4'b0000, offset, 1'b0} :
                    jmpb ? {1'b0, pc} - {4'b0000, offset, 1'b0} :
                           {1'b0, pc} + 9'd1;
  // Sequencer FSM with registered request, instruction, pulse and status outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      retired     <= '0;
`ifdef PC_WRAP_TRAP_EN
      fault       <= 1'b0;
`endif
    end else begin
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: state <= WAIT;
        WAIT: if (imem_ack) begin
          instr       <= imem_data;
          instr_valid <= 1'b1;
          state       <= EXEC;
        end
        EXEC: if (exec_done) begin
          if (~&retired) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
          if (halt_req || (TRAP && nxt[8])) begin
            state  <= HALT;
            halted <= 1'b1;
`ifdef PC_WRAP_TRAP_EN
            if (!halt_req) fault <= 1'b1;
`endif
          end else begin
            pc       <= nxt[7:0];
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against an integer reference model
module tb_pc_sequencer;
`ifdef PC_WRAP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int RMAX = 15;
  logic clk = 0, reset = 0, start = 0, imem_ack = 0, exec_done = 0;
  logic jmpf = 0, jmpb = 0, halt_req = 0;
  logic [3:0] offset = 0;
  logic [8:0] imem_data = 0;
  logic imem_req, instr_valid, halted;
  logic [7:0] imem_addr, pc;
  logic [8:0] instr;
  logic [3:0] retired;
`ifdef PC_WRAP_TRAP_EN
  logic fault;
`endif
  int n_assert = 0, n_fail = 0;
  int e_pc, e_ret;
  logic [8:0] e_instr;
  bit e_halt, e_fault;

  pc_sequencer #(.RESET_PC(8'h00), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .jmpf(jmpf), .jmpb(jmpb), .offset(offset), .halt_req(halt_req),
    .pc(pc), .halted(halted),
`ifdef PC_WRAP_TRAP_EN
    .fault(fault),
`endif
    .retired(retired));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start = 0; imem_ack = 0; exec_done = 0; jmpf = 0; jmpb = 0; halt_req = 0; offset = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".retired"}, retired, e_ret);
    chk({tag, ".halted"}, halted, e_halt);
    chk({tag, ".instr"}, instr, e_instr);
`ifdef PC_WRAP_TRAP_EN
    chk({tag, ".fault"}, fault, e_fault);
`endif
  endtask

  task automatic do_reset();
    clr();
    reset = 1;
    #2;
    e_pc = 0; e_ret = 0; e_instr = 0; e_halt = 0; e_fault = 0;
    chk("reset.imem_req", imem_req, 0);
    chk("reset.instr_valid", instr_valid, 0);
    chk_state("reset");
    tick();
    reset = 0;
    tick();
    chk("idle.imem_req", imem_req, 0);
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
    chk("start.imem_req", imem_req, 1);
    chk("start.imem_addr", imem_addr, e_pc);
  endtask

  // Entered in FETCH; leaves in EXEC right after the instr_valid pulse
  task automatic do_fetch(input logic [8:0] d, input int waits, input bit spur);
    if (spur) begin
      imem_ack = 1; imem_data = ~d; exec_done = 1; jmpf = 1; offset = 3; start = 1;
    end
    tick();
    clr();
    chk("fetch.req_drop", imem_req, 0);
    chk("fetch.valid", instr_valid, 0);
    chk_state("fetch");
    if (spur) begin
      exec_done = 1; jmpb = 1; offset = 2; start = 1;
      tick();
      clr();
      chk("wait_spur.valid", instr_valid, 0);
      chk("wait_spur.req", imem_req, 0);
      chk_state("wait_spur");
    end
    repeat (waits) tick();
    chk("wait.valid", instr_valid, 0);
    imem_ack = 1; imem_data = d;
    tick();
    imem_ack = 0;
    e_instr = d;
    chk("ack.valid", instr_valid, 1);
    chk("ack.instr", instr, d);
    if (spur) begin
      start = 1;
      tick();
      start = 0;
      chk("exec_spur.valid", instr_valid, 0);
      chk("exec_spur.req", imem_req, 0);
      chk_state("exec_spur");
    end
  endtask

  task automatic do_exec(input bit h, input bit f, input bit b, input int off);
    int p;
    exec_done = 1; halt_req = h; jmpf = f; jmpb = b; offset = off[3:0];
    tick();
    clr();
    e_ret = (e_ret < RMAX) ? e_ret + 1 : RMAX;
    if (h) e_halt = 1;
    else begin
      p = e_pc + (f ? 2 * off : b ? -2 * off : 1);
      if (TRAP && (p < 0 || p > 255)) begin
        e_halt = 1; e_fault = 1;
      end else e_pc = (p + 256) % 256;
    end
    chk("exec.imem_req", imem_req, !e_halt);
    chk("exec.valid", instr_valid, 0);
    chk("exec.imem_addr", imem_addr, e_pc);
    chk_state("exec");
  endtask

  initial begin
    do_reset();
    do_start();
    do_fetch(9'h1A5, 2, 0);
    do_exec(0, 0, 0, 0);
    chk("first.pc", pc, 8'h01);
    do_fetch(9'h0C3, 1, 1);
    do_exec(0, 1, 0, 7);
    do_fetch(9'h011, 0, 0);
    do_exec(0, 0, 0, 0);
    chk("pc10", pc, 8'h10);
    do_fetch(9'h022, 0, 0);
    do_exec(0, 1, 0, 3);
    chk("jmpf3", pc, 8'h16);
    do_fetch(9'h033, 3, 0);
    do_exec(0, 0, 1, 5);
    chk("jmpb5", pc, 8'h0C);
    do_fetch(9'h044, 0, 0);
    do_exec(0, 1, 0, 10);
    do_fetch(9'h055, 0, 0);
    do_exec(0, 1, 1, 1);
    chk("both_jmp", pc, 8'h22);
    do_fetch(9'h066, 0, 0);
    do_exec(0, 0, 1, 1);
    do_fetch(9'h077, 0, 0);
    do_exec(0, 1, 0, 0);
    chk("self_loop", pc, 8'h20);
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 3);
      do_fetch(9'($urandom), $urandom_range(0, 3), 0);
      do_exec(0, op[0], op[1], $urandom_range(0, 15));
      if (e_halt) break;
    end
    chk("ret_sat", retired, 4'hF);
    if (!e_halt) begin
      do_fetch(9'h188, 1, 0);
      do_exec(1, 1, 1, 4);
    end
    chk("halted", halted, 1);
    start = 1; exec_done = 1; imem_ack = 1; jmpf = 1; offset = 1;
    repeat (3) tick();
    clr();
    chk("halt.req", imem_req, 0);
    chk("halt.valid", instr_valid, 0);
    chk_state("halt_hold");

    do_reset();
    do_start();
    reset = 1;
    #1;
    chk("rst_fetch.req", imem_req, 0);
    tick();
    reset = 0;
    do_start();
    tick();
    imem_data = 9'h1FF;
    reset = 1;
    #1;
    chk("rst_wait.req", imem_req, 0);
    chk("rst_wait.instr", instr, 0);
    tick();
    reset = 0;
    imem_ack = 1;
    repeat (3) begin
      tick();
      chk("rst_ack.valid", instr_valid, 0);
      chk("rst_ack.req", imem_req, 0);
      chk("rst_ack.instr", instr, 0);
    end
    imem_ack = 0;
    do_start();
    do_fetch(9'h101, 0, 0);
    do_exec(0, 0, 0, 0);
    chk("rst_resume.pc", pc, 8'h01);

    do_reset();
    do_start();
    for (int i = 0; i < 8; i++) begin
      do_fetch(9'(i), 0, 0);
      do_exec(0, 1, 0, 15);
    end
    for (int i = 0; i < 15; i++) begin
      do_fetch(9'(i + 8), 0, 0);
      do_exec(0, 0, 0, 0);
    end
    chk("pc_ff", pc, 8'hFF);
    do_fetch(9'h0FF, 0, 0);
    do_exec(0, 0, 0, 0);
    chk("wrap_inc.pc", pc, TRAP ? 8'hFF : 8'h00);
    chk("wrap_inc.halted", halted, TRAP);

    do_reset();
    do_start();
    do_fetch(9'h002, 0, 0);
    do_exec(0, 0, 1, 4);
    chk("wrap_jmpb.pc", pc, TRAP ? 8'h00 : 8'hF8);
    chk("wrap_jmpb.halted", halted, TRAP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
